column_caster: RTL and testbench

COLUMN_CASTER -- requirements
Module: column_caster

---
 rtl/column_caster.sv | 147 ++++++++++++++
 tb/tb_column_caster.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/column_caster.sv
// Casts one ray per screen column through an external ray tracer and emits one record per column.
// Latency: ISSUE + trace time + OUTPUT per column; frame_done one cycle after the last record is accepted.
// Backpressure: holds the column record with col_valid until col_ready; no new ray is issued meanwhile.
module column_caster #(
   parameter int NUM_COLS  = 160,
   parameter int COL_SHIFT = 2,
   parameter int HALF_FOV  = 20
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        i_frame_start,
   input  logic [13:0] i_player_x,
   input  logic [12:0] i_player_y,
   input  logic [7:0]  i_player_angle,
   output logic        o_busy,
   output logic        o_frame_done,
   output logic        o_rt_start,
   output logic [13:0] o_rt_x,
   output logic [12:0] o_rt_y,
   output logic [7:0]  o_rt_angle,
   input  logic        i_rt_done,
   input  logic [5:0]  i_rt_result_x,
   input  logic [4:0]  i_rt_result_y,
   output logic        o_col_valid,
   input  logic        i_col_ready,
   output logic [7:0]  o_col_index,
   output logic [5:0]  o_col_hit_x,
   output logic [4:0]  o_col_hit_y,
   output logic [11:0] o_col_dist
);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_RT,
      OUTPUT,
      FRAME_DONE
   } state_t;

   localparam logic [7:0]  LAST_COL = 8'(NUM_COLS - 1);
   localparam logic [7:0]  FOV_OFS  = 8'(HALF_FOV);
   localparam logic [11:0] DIST_MAX = 12'hFFF;

   state_t      r_state;
   logic [13:0] r_pose_x;
   logic [12:0] r_pose_y;
   logic [7:0]  r_pose_angle;
   logic [7:0]  r_col;
   logic [11:0] r_dist;
   logic        r_rt_start;
   logic        r_col_valid;
   logic        r_frame_done;
   logic [5:0]  r_col_hit_x;
   logic [4:0]  r_col_hit_y;
   logic [11:0] r_col_dist;

   logic [7:0]  w_rt_angle;
   logic        w_handshake;

   // Ray angle derives only from registered pose and column, so it is stable for the whole ray.
   assign w_rt_angle  = r_pose_angle - FOV_OFS + (r_col >> COL_SHIFT);
   assign w_handshake = r_col_valid & i_col_ready;

   // Frame sequencer: one ray in flight, record held until accepted, all outputs registered.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state      <= IDLE;
         r_pose_x     <= '0;
         r_pose_y     <= '0;
         r_pose_angle <= '0;
         r_col        <= '0;
         r_dist       <= '0;
         r_rt_start   <= 1'b0;
         r_col_valid  <= 1'b0;
         r_frame_done <= 1'b0;
         r_col_hit_x  <= '0;
         r_col_hit_y  <= '0;
         r_col_dist   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               // A stale rt_done here is deliberately ignored.
               if (i_frame_start) begin
                  r_pose_x     <= i_player_x;
                  r_pose_y     <= i_player_y;
                  r_pose_angle <= i_player_angle;
                  r_col        <= '0;
                  r_rt_start   <= 1'b1;
                  r_state      <= ISSUE;
               end
            end
            ISSUE: begin
               r_rt_start <= 1'b0;
               r_dist     <= '0;
               r_state    <= WAIT_RT;
            end
            WAIT_RT: begin
               if (i_rt_done) begin
                  r_col_hit_x <= i_rt_result_x;
                  r_col_hit_y <= i_rt_result_y;
                  r_col_dist  <= r_dist;
                  r_col_valid <= 1'b1;
                  r_state     <= OUTPUT;
               end else if (r_dist != DIST_MAX) begin
                  r_dist <= r_dist + 12'd1;
               end
            end
            OUTPUT: begin
               if (w_handshake) begin
                  r_col_valid <= 1'b0;
                  if (r_col == LAST_COL) begin
                     r_frame_done <= 1'b1;
                     r_state      <= FRAME_DONE;
                  end else begin
                     r_col      <= r_col + 8'd1;
                     r_rt_start <= 1'b1;
                     r_state    <= ISSUE;
                  end
               end
            end
            FRAME_DONE: begin
               r_frame_done <= 1'b0;
               r_state      <= IDLE;
            end
            default: begin
               r_rt_start   <= 1'b0;
               r_col_valid  <= 1'b0;
               r_frame_done <= 1'b0;
               r_state      <= IDLE;
            end
         endcase
      end
   end

   assign o_busy       = (r_state != IDLE);
   assign o_frame_done = r_frame_done;
   assign o_rt_start   = r_rt_start;
   assign o_rt_x       = r_pose_x;
   assign o_rt_y       = r_pose_y;
   assign o_rt_angle   = w_rt_angle;
   assign o_col_valid  = r_col_valid;
   assign o_col_index  = r_col;
   assign o_col_hit_x  = r_col_hit_x;
   assign o_col_hit_y  = r_col_hit_y;
   assign o_col_dist   = r_col_dist;

endmodule

// File: tb/tb_column_caster.sv
// Directed bench for column_caster: full frames from a vector table plus a mid-frame reset sequence.
// A negedge ray tracer model answers each rt_start after 2+2k WAIT_RT cycles.
// Outputs are sampled and inputs driven on the falling edge.
module tb_column_caster;

   logic        clock = 1'b0;
   logic        reset;
   logic        frame_start;
   logic [13:0] player_x;
   logic [12:0] player_y;
   logic [7:0]  player_angle;
   logic        busy, frame_done, rt_start;
   logic [13:0] rt_x;
   logic [12:0] rt_y;
   logic [7:0]  rt_angle;
   logic        rt_done;
   logic [5:0]  rt_result_x;
   logic [4:0]  rt_result_y;
   logic        col_valid, col_ready;
   logic [7:0]  col_index;
   logic [5:0]  col_hit_x;
   logic [4:0]  col_hit_y;
   logic [11:0] col_dist;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clock = ~clock;

   column_caster dut (
      .clock(clock), .reset(reset),
      .i_frame_start(frame_start), .i_player_x(player_x), .i_player_y(player_y),
      .i_player_angle(player_angle),
      .o_busy(busy), .o_frame_done(frame_done),
      .o_rt_start(rt_start), .o_rt_x(rt_x), .o_rt_y(rt_y), .o_rt_angle(rt_angle),
      .i_rt_done(rt_done), .i_rt_result_x(rt_result_x), .i_rt_result_y(rt_result_y),
      .o_col_valid(col_valid), .i_col_ready(col_ready),
      .o_col_index(col_index), .o_col_hit_x(col_hit_x), .o_col_hit_y(col_hit_y),
      .o_col_dist(col_dist)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Ray tracer model
   int         slow_col = 999;
   int         slow_k   = 0;
   int         m_col    = 0;
   int         m_wait   = 0;
   bit         m_active = 0;
   logic [5:0] m_rx;
   logic [4:0] m_ry;

   always @(negedge clock) begin
      rt_done = 1'b0;
      if (!busy) m_col = 0;
      if (m_active) begin
         if (m_wait == 0) begin
            rt_done     = 1'b1;
            rt_result_x = m_rx;
            rt_result_y = m_ry;
            m_active    = 0;
         end else begin
            m_wait--;
         end
      end
      if (rt_start) begin
         m_active = 1;
         m_wait   = (m_col == slow_col) ? 2 + 2 * slow_k : 2;
         m_rx     = 6'(m_col);
         m_ry     = 5'((m_col + 3) % 32);
         m_col++;
      end
   end

   typedef struct {
      logic [13:0] px;
      logic [12:0] py;
      logic [7:0]  ang;
      int          slow_col;
      int          slow_k;
      int          stall_col;
      bit          repulse;
      logic [7:0]  a0;
      logic [7:0]  a159;
   } vec_t;

   vec_t vecs[3];

   task automatic run_frame(input vec_t v, input string tag);
      int         ec = 0;
      int         stall = 0;
      bit         fin = 0;
      bit         pulsed = 0;
      logic [7:0] exp_ang;
      logic [7:0] s_idx;
      logic [5:0] s_hx;
      logic [4:0] s_hy;
      logic [11:0] s_d;
      logic [11:0] exp_d;
      slow_col     = v.slow_col;
      slow_k       = v.slow_k;
      player_x     = v.px;
      player_y     = v.py;
      player_angle = v.ang;
      col_ready    = 1'b1;
      frame_start  = 1'b1;
      for (int cyc = 0; cyc < 6000 && !fin; cyc++) begin
         @(negedge clock);
         frame_start = 1'b0;
         if (v.repulse && ec == 20 && !pulsed) begin
            frame_start  = 1'b1;
            player_x     = v.px + 14'd1234;
            player_y     = v.py + 13'd777;
            player_angle = v.ang + 8'd77;
            pulsed       = 1;
         end
         if (rt_start) begin
            exp_ang = v.ang - 8'd20 + 8'(ec >> 2);
            chk({tag, " rt_x"}, 32'(rt_x), 32'(v.px));
            chk({tag, " rt_y"}, 32'(rt_y), 32'(v.py));
            chk({tag, " rt_angle"}, 32'(rt_angle), 32'(exp_ang));
            if (ec == 0)   chk({tag, " rt_angle_col0"}, 32'(rt_angle), 32'(v.a0));
            if (ec == 159) chk({tag, " rt_angle_col159"}, 32'(rt_angle), 32'(v.a159));
         end
         col_ready = !(ec == v.stall_col && stall < 10);
         if (col_valid && !col_ready) begin
            if (stall == 0) begin
               s_idx = col_index; s_hx = col_hit_x; s_hy = col_hit_y; s_d = col_dist;
            end else begin
               chk({tag, " stall_idx"}, 32'(col_index), 32'(s_idx));
               chk({tag, " stall_hx"}, 32'(col_hit_x), 32'(s_hx));
               chk({tag, " stall_hy"}, 32'(col_hit_y), 32'(s_hy));
               chk({tag, " stall_dist"}, 32'(col_dist), 32'(s_d));
            end
            chk({tag, " stall_no_rt_start"}, 32'(rt_start), 32'd0);
            stall++;
         end else if (col_valid && col_ready) begin
            exp_d = (ec == v.slow_col) ? 12'(2 + 2 * v.slow_k) : 12'd2;
            chk({tag, " col_index"}, 32'(col_index), 32'(ec));
            chk({tag, " col_hit_x"}, 32'(col_hit_x), 32'(ec % 64));
            chk({tag, " col_hit_y"}, 32'(col_hit_y), 32'((ec + 3) % 32));
            chk({tag, " col_dist"}, 32'(col_dist), 32'(exp_d));
            ec++;
         end
         if (frame_done) begin
            chk({tag, " cols_at_frame_done"}, 32'(ec), 32'd160);
            fin = 1;
         end
      end
      chk({tag, " frame_finished"}, 32'(fin), 32'd1);
      if (v.stall_col < 160) chk({tag, " stall_cycles"}, 32'(stall), 32'd10);
      frame_start = 1'b0;
      @(negedge clock);
      chk({tag, " frame_done_single"}, 32'(frame_done), 32'd0);
      chk({tag, " idle_after_frame"}, 32'(busy), 32'd0);
      repeat (3) @(negedge clock);
   endtask

   initial begin
      vecs[0] = '{px: 14'd100, py: 13'd200, ang: 8'd30,  slow_col: 3,   slow_k: 5, stall_col: 999,
                  repulse: 1'b0, a0: 8'd10,  a159: 8'd49};
      vecs[1] = '{px: 14'd5000, py: 13'd4000, ang: 8'd5, slow_col: 999, slow_k: 0, stall_col: 7,
                  repulse: 1'b0, a0: 8'd241, a159: 8'd24};
      vecs[2] = '{px: 14'd16383, py: 13'd8191, ang: 8'd250, slow_col: 999, slow_k: 0, stall_col: 999,
                  repulse: 1'b1, a0: 8'd230, a159: 8'd13};

      reset = 1'b1; frame_start = 1'b0; col_ready = 1'b0;
      player_x = '0; player_y = '0; player_angle = '0;
      rt_done = 1'b0; rt_result_x = '0; rt_result_y = '0;
      repeat (3) @(negedge clock);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst rt_start", 32'(rt_start), 32'd0);
      chk("rst col_valid", 32'(col_valid), 32'd0);
      chk("rst frame_done", 32'(frame_done), 32'd0);
      chk("rst col_index", 32'(col_index), 32'd0);
      chk("rst col_dist", 32'(col_dist), 32'd0);
      chk("rst rt_x", 32'(rt_x), 32'd0);
      reset = 1'b0;
      @(negedge clock);
      chk("idle busy", 32'(busy), 32'd0);

      for (int i = 0; i < 3; i++) run_frame(vecs[i], $sformatf("v%0d", i));

      // Reset while column 50 is waiting on the ray tracer.
      begin
         int  ec = 0;
         bit  hit = 0;
         slow_col = 999;
         player_x = 14'd300; player_y = 13'd400; player_angle = 8'd60;
         col_ready = 1'b1;
         frame_start = 1'b1;
         for (int cyc = 0; cyc < 2000 && !hit; cyc++) begin
            @(negedge clock);
            frame_start = 1'b0;
            if (rt_start && ec == 50) hit = 1;
            else if (col_valid && col_ready) ec++;
         end
         chk("mid reset reached col50", 32'(hit), 32'd1);
         @(negedge clock);
         reset = 1'b1;
         @(negedge clock);
         chk("mid reset busy", 32'(busy), 32'd0);
         chk("mid reset col_valid", 32'(col_valid), 32'd0);
         chk("mid reset rt_start", 32'(rt_start), 32'd0);
         chk("mid reset col_index", 32'(col_index), 32'd0);
         chk("mid reset col_hit_x", 32'(col_hit_x), 32'd0);
         chk("mid reset rt_x", 32'(rt_x), 32'd0);
         reset = 1'b0;
         repeat (8) @(negedge clock);
         chk("stale rt_done ignored busy", 32'(busy), 32'd0);
         chk("stale rt_done ignored col_valid", 32'(col_valid), 32'd0);
      end

      run_frame(vecs[0], "restart");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
